// File: rtl/mult_div_if.sv
// Handshake and result bus between the CPU control path and the multiply/divide engine.
//   start      request from the control FSM (sampled only while the engine is idle)
//   func_code  6-bit function field: MULT / MULTU / DIV / DIVU
//   op_a/op_b  rs / rt operand values
//   busy       engine is working; control holds EXECUTE while high
//   done       one-cycle pulse marking a fresh {HI,LO} result
//   div_zero   sticky divide-by-zero flag for the most recent operation
//   result     {HI,LO}
// master: the requesting side (control / testbench); slave: the engine.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [5:0]           func_code;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 busy;
    logic                 done;
    logic                 div_zero;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, func_code, op_a, op_b,
        input  busy, done, div_zero, result
    );

    modport slave (
        input  start, func_code, op_a, op_b,
        output busy, done, div_zero, result
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine producing the 64-bit {HI,LO} value for
// MULT, MULTU, DIV and DIVU. One bit per cycle: radix-2 shift-add multiply,
// restoring divide. Signed operations run on magnitudes and are sign-corrected
// in a final FIXUP cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (aborts any operation in flight)
//   bus    mult_div_if.slave: start/func_code/op_a/op_b in,
//          busy/done/div_zero/result out
// Timeline for a start accepted at edge 0: PREP after edge 0, CALC for WIDTH
// cycles (edges 1..WIDTH), FIXUP, DONE (done high between edges WIDTH+2 and
// WIDTH+3), back to IDLE. Divide by zero skips straight from PREP to DONE.
module mult_div_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] DIVZERO_LO = '1
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_CALC  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // op_reg[1]: divide, op_reg[0]: unsigned (mirrors func_code[1:0])
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;      // raw rt in PREP, then |rt| as multiplicand/divisor
    logic [WIDTH-1:0]   hi_reg;     // partial product high half / partial remainder
    logic [WIDTH-1:0]   lo_reg;     // multiplier shifting out / dividend-quotient
    logic [CW-1:0]      count_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               div_zero_reg;
    logic [2*WIDTH-1:0] result_reg;

    logic legal_func;
    logic is_div;
    logic is_signed;
    logic b_is_zero;

    assign legal_func = (bus.func_code[5:2] == 4'b0110);
    assign is_div     = op_reg[1];
    assign is_signed  = ~op_reg[0];
    assign b_is_zero  = (b_reg == '0);

    // ---------------- combinational datapath ----------------
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_next;
    logic [WIDTH-1:0]   mul_lo_next;
    logic [WIDTH:0]     div_shifted;
    logic               div_fits;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] fixed_result;

    always_comb begin
        abs_a = (is_signed && a_reg[WIDTH-1]) ? (~a_reg + 1'b1) : a_reg;
        abs_b = (is_signed && b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;

        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole {carry,hi,lo} right.
        mul_sum     = lo_reg[0] ? ({1'b0, hi_reg} + {1'b0, b_reg}) : {1'b0, hi_reg};
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

        // Restoring divide: the partial remainder is always below the divisor,
        // so the shifted value is below 2*divisor and the difference fits WIDTH bits.
        div_shifted  = {hi_reg, lo_reg[WIDTH-1]};
        div_fits     = (div_shifted >= {1'b0, b_reg});
        div_diff     = div_shifted[WIDTH-1:0] - b_reg;
        div_rem_next = div_fits ? div_diff : div_shifted[WIDTH-1:0];
        div_quo_next = {lo_reg[WIDTH-2:0], div_fits};

        product = {hi_reg, lo_reg};
        if (is_div) begin
            fixed_result = {(sign_r_reg ? (~hi_reg + 1'b1) : hi_reg),
                            (sign_q_reg ? (~lo_reg + 1'b1) : lo_reg)};
        end else begin
            fixed_result = sign_q_reg ? (~product + 1'b1) : product;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (bus.start && legal_func) state_next = S_PREP;
            S_PREP:  state_next = (is_div && b_is_zero) ? S_DONE : S_CALC;
            S_CALC:  if (count_reg == LAST_COUNT) state_next = S_FIXUP;
            S_FIXUP: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            count_reg    <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (bus.start && legal_func) begin
                        op_reg <= bus.func_code[1:0];
                        a_reg  <= bus.op_a;
                        b_reg  <= bus.op_b;
                    end
                end
                S_PREP: begin
                    sign_q_reg <= is_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    sign_r_reg <= is_signed & a_reg[WIDTH-1];
                    hi_reg     <= '0;
                    lo_reg     <= abs_a;
                    b_reg      <= abs_b;
                    count_reg  <= '0;
                    if (is_div && b_is_zero) begin
                        result_reg   <= {a_reg, DIVZERO_LO};
                        div_zero_reg <= 1'b1;
                    end else begin
                        div_zero_reg <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        hi_reg <= div_rem_next;
                        lo_reg <= div_quo_next;
                    end else begin
                        hi_reg <= mul_hi_next;
                        lo_reg <= mul_lo_next;
                    end
                    count_reg <= count_reg + 1'b1;
                end
                S_FIXUP: begin
                    // Written on the edge into DONE so it is valid with the done pulse.
                    result_reg <= fixed_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = (state_reg != S_IDLE);
    assign bus.done     = (state_reg == S_DONE);
    assign bus.div_zero = div_zero_reg;
    assign bus.result   = result_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed check of mult_div_unit against an arithmetic
// reference model (SV longint multiply / divide).
module tb_mult_div_unit;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .DIVZERO_LO(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [63:0] last_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // One operation: start accepted at the next rising edge, then wait for done.
    // interfere pulses a second start (which must be ignored) 10 cycles in.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit interfere);
        logic [63:0] exp;
        int exp_lat;
        logic exp_dz;
        int cyc;
        exp     = model(f, a, b);
        exp_dz  = f[1] && (b == 0);
        exp_lat = exp_dz ? 1 : 34;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.func_code = f;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (interfere && cyc == 10) begin
                bus.start     = 1'b1;
                bus.func_code = F_DIV;
                bus.op_a      = 32'd5;
                bus.op_b      = 32'd0;
            end else if (interfere && cyc == 11) begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " result"}, bus.result, exp);
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        $display("op %s f=%b a=%h b=%h -> result=%h dz=%0d lat=%0d",
                 tag, f, a, b, bus.result, bus.div_zero, cyc);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, " busy_end"}, 64'(bus.busy), 64'd0);
        last_exp = exp;
    endtask

    initial begin
        logic [5:0] f;
        logic [31:0] a, b;
        bit done_seen;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.func_code = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        check("reset result", bus.result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max value", last_exp, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("div_zero", F_DIV, 32'h1234_5678, 32'd0, 1'b0);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_min", F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_zero", F_DIVU, 32'hCAFE_0001, 32'd0, 1'b0);
        run_op("multu_interf", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Illegal function code: must be ignored, result untouched.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.func_code = 6'b100000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("illegal busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check("illegal result", bus.result, last_exp);
        $display("op illegal f=100000 ignored");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom();
            b = $urandom();
            if ($urandom_range(7) == 0) b = 32'd0;
            else if ($urandom_range(7) == 0) b = $urandom_range(15);
            if ($urandom_range(9) == 0) a = 32'h8000_0000;
            run_op($sformatf("rnd%0d", i), f, a, b, 1'b0);
        end

        // Reset in the middle of CALC.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.func_code = F_MULT;
        bus.op_a      = 32'h1234_5678;
        bus.op_b      = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset result", bus.result, 64'd0);
        check("midreset div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1'b1;
        end
        check("midreset no_done", 64'(done_seen), 64'd0);
        $display("op midreset aborted");
        run_op("after_reset", F_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
